pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the 5-stage core (if_id, id_ex, ex_mem, mem_wb).
- Carries a flat payload bus, a valid bit and a "sticky" sideband field, such as next-inst-in-delay-slot.
- Handles flush, bubble insertion and hold from the central stall vector.
- Adds saturating bubble/flush event counters for performance debug.

---
 rtl/pipe_stage_reg_pkg.sv | 37 +++
 rtl/pipe_stage_reg_sat_counter.sv | 23 ++
 rtl/pipe_stage_reg.sv | 100 ++++++++++
 tb/tb_pipe_stage_reg.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stall polarity, bus widths, stage indices,
// per-stage NOP field encodings and the per-cycle register action decode.
package pipe_stage_reg_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam int unsigned STALL_BUS_W = 6;

  typedef enum logic [2:0] {
    STG_IF  = 3'd0,
    STG_ID  = 3'd1,
    STG_EX  = 3'd2,
    STG_MEM = 3'd3,
    STG_WB  = 3'd4
  } stg_e;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [2:0] EXE_RES_NOP  = 3'b000;
  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_FLUSH
  } act_e;

  // Flush beats every stall pattern; up=0 with dn=1 falls through to advance.
  function automatic act_e decode_act(input logic flush, input logic up, input logic dn);
    if (flush)          return ACT_FLUSH;
    else if (up && !dn) return ACT_BUBBLE;
    else if (up && dn)  return ACT_HOLD;
    else                return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear that outranks increment.
module sat_counter
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with flush/bubble/hold control from the
// central stall vector and saturating bubble/flush event counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W     = 128,
  parameter int unsigned       STICKY_W   = 1,
  parameter int unsigned       STALL_W    = STALL_BUS_W,
  parameter int unsigned       STAGE_IDX  = 32'(STG_EX),
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter logic [STICKY_W-1:0] STICKY_RST = '0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush_i,
  input  logic                in_valid_i,
  input  logic [DATA_W-1:0]   in_data_i,
  input  logic [STICKY_W-1:0] in_sticky_i,
  input  logic                cnt_clr_i,
  output logic                out_valid_o,
  output logic [DATA_W-1:0]   out_data_o,
  output logic [STICKY_W-1:0] out_sticky_o,
  output logic [CNT_W-1:0]    bubble_cnt_o,
  output logic [CNT_W-1:0]    flush_cnt_o
);

  if (STAGE_IDX > STALL_W - 2) begin : g_bad_stage_idx
    $fatal(1, "pipe_stage_reg: STAGE_IDX %0d out of range for STALL_W %0d", STAGE_IDX, STALL_W);
  end

  logic up;
  logic dn;
  act_e act;
  logic bubble_inc;
  logic flush_inc;

  always_comb begin
    up  = (stall[STAGE_IDX]   == STOP);
    dn  = (stall[STAGE_IDX+1] == STOP);
    act = decode_act(flush_i, up, dn);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid_o  <= 1'b0;
      out_data_o   <= BUBBLE_VAL;
      out_sticky_o <= STICKY_RST;
    end else begin
      unique case (act)
        ACT_FLUSH: begin
          out_valid_o  <= 1'b0;
          out_data_o   <= BUBBLE_VAL;
          out_sticky_o <= STICKY_RST;
        end
        // Sticky sideband survives a bubble so delay-slot state is kept.
        ACT_BUBBLE: begin
          out_valid_o <= 1'b0;
          out_data_o  <= BUBBLE_VAL;
        end
        ACT_HOLD: ;
        ACT_ADVANCE: begin
          out_valid_o  <= in_valid_i;
          out_data_o   <= in_data_i;
          out_sticky_o <= in_sticky_i;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bubble_inc = (act == ACT_BUBBLE);
    flush_inc  = (act == ACT_FLUSH) && out_valid_o;
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .inc   (bubble_inc),
    .clr   (cnt_clr_i),
    .count (bubble_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .inc   (flush_inc),
    .clr   (cnt_clr_i),
    .count (flush_cnt_o)
  );

  // Ctrl stalls are monotonic: a stopped stage implies every earlier stage is
  // stopped, which in particular rules out up=0 with dn=1 for this register.
  a_stall_monotonic: assert property (@(posedge Clk) disable iff (!Rst_n)
    (((stall >> 1) & ~stall) == '0))
    else $error("pipe_stage_reg: non-monotonic stall vector %b", stall);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench for pipe_stage_reg (DATA_W=128, STAGE_IDX=2, CNT_W=4).
module tb_pipe_stage_reg;

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 4;

  logic          Clk;
  logic          Rst_n;
  logic [5:0]    stall;
  logic          flush_i;
  logic          in_valid_i;
  logic [DW-1:0] in_data_i;
  logic          in_sticky_i;
  logic          cnt_clr_i;
  logic          out_valid_o;
  logic [DW-1:0] out_data_o;
  logic          out_sticky_o;
  logic [CW-1:0] bubble_cnt_o;
  logic [CW-1:0] flush_cnt_o;

  pipe_stage_reg #(
    .DATA_W    (DW),
    .STICKY_W  (1),
    .STALL_W   (6),
    .STAGE_IDX (2),
    .CNT_W     (CW)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .stall        (stall),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_sticky_i  (in_sticky_i),
    .cnt_clr_i    (cnt_clr_i),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_sticky_o (out_sticky_o),
    .bubble_cnt_o (bubble_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          s;
    logic [CW-1:0] b;
    logic [CW-1:0] f;
  } exp_t;

  exp_t q[$];
  int unsigned tests = 0;
  int unsigned failed = 0;

  logic          m_v;
  logic [DW-1:0] m_d;
  logic          m_s;
  logic [CW-1:0] m_b;
  logic [CW-1:0] m_f;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 1'b0; m_d = '0; m_s = 1'b0; m_b = '0; m_f = '0;
  endtask

  // Drive one cycle of stimulus, push the expected post-edge state, then pop
  // and compare after the edge.
  task automatic step(input string tag, input logic fl, input logic [5:0] st,
                      input logic v, input logic [DW-1:0] d, input logic s,
                      input logic clr);
    exp_t e;
    logic up, dn;
    flush_i = fl; stall = st; in_valid_i = v; in_data_i = d; in_sticky_i = s;
    cnt_clr_i = clr;
    up = st[2];
    dn = st[3];
    if (fl) begin
      if (m_v && m_f != 4'hF) m_f = m_f + 1'b1;
      m_v = 1'b0; m_d = '0; m_s = 1'b0;
    end else if (up && !dn) begin
      if (m_b != 4'hF) m_b = m_b + 1'b1;
      m_v = 1'b0; m_d = '0;
    end else if (!up) begin
      m_v = v; m_d = d; m_s = s;
    end
    if (clr) begin
      m_b = '0; m_f = '0;
    end
    e.v = m_v; e.d = m_d; e.s = m_s; e.b = m_b; e.f = m_f;
    q.push_back(e);
    @(posedge Clk);
    #1;
    if (q.size() == 0) begin
      tests++;
      failed++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".valid"},  DW'(out_valid_o),  DW'(e.v));
      chk({tag, ".data"},   out_data_o,        e.d);
      chk({tag, ".sticky"}, DW'(out_sticky_o), DW'(e.s));
      chk({tag, ".bcnt"},   DW'(bubble_cnt_o), DW'(e.b));
      chk({tag, ".fcnt"},   DW'(flush_cnt_o),  DW'(e.f));
    end
  endtask

  initial begin
    logic [DW-1:0] pat_a5;
    pat_a5 = {16{8'hA5}};
    Rst_n = 1'b0; stall = '0; flush_i = 1'b0; in_valid_i = 1'b0;
    in_data_i = '0; in_sticky_i = 1'b0; cnt_clr_i = 1'b0;
    model_reset();
    #2;
    chk("rst.valid", DW'(out_valid_o), '0);
    chk("rst.data",  out_data_o, '0);
    chk("rst.bcnt",  DW'(bubble_cnt_o), '0);
    chk("rst.fcnt",  DW'(flush_cnt_o), '0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    step("adv", 1'b0, 6'b000000, 1'b1, DW'(128'h1234), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("bub", 1'b0, 6'b000111, 1'b1, DW'(128'hDEAD), 1'b0, 1'b0);
    chk("bub.sticky_kept", DW'(out_sticky_o), DW'(1'b1));
    chk("bub.count3", DW'(bubble_cnt_o), DW'(4'd3));

    step("load_beef", 1'b0, 6'b000000, 1'b1, DW'(128'hBEEF), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step("hold", 1'b0, 6'b001111, 1'b0, DW'(128'h7777), 1'b1, 1'b0);
    chk("hold.data", out_data_o, DW'(128'hBEEF));
    chk("hold.valid", DW'(out_valid_o), DW'(1'b1));

    step("load_s1", 1'b0, 6'b000000, 1'b1, DW'(128'h42), 1'b1, 1'b0);
    step("flush1", 1'b1, 6'b000111, 1'b1, DW'(128'h99), 1'b1, 1'b0);
    chk("flush1.fcnt", DW'(flush_cnt_o), DW'(4'd1));
    chk("flush1.bcnt", DW'(bubble_cnt_o), DW'(4'd3));
    step("flush2", 1'b1, 6'b000000, 1'b1, DW'(128'h99), 1'b1, 1'b0);
    chk("flush2.fcnt", DW'(flush_cnt_o), DW'(4'd1));

    step("adv_inval", 1'b0, 6'b000000, 1'b0, DW'(128'h55), 1'b0, 1'b0);
    chk("adv_inval.data", out_data_o, DW'(128'h55));

    for (int i = 0; i < 20; i++)
      step("sat", 1'b0, 6'b000111, 1'b0, '0, 1'b0, 1'b0);
    chk("sat.bcnt", DW'(bubble_cnt_o), DW'(4'hF));
    step("clr_bub", 1'b0, 6'b000111, 1'b0, '0, 1'b0, 1'b1);
    chk("clr.bcnt", DW'(bubble_cnt_o), '0);
    chk("clr.fcnt", DW'(flush_cnt_o), '0);

    step("load_a5", 1'b0, 6'b000000, 1'b1, pat_a5, 1'b1, 1'b0);
    step("bub_a5", 1'b0, 6'b000111, 1'b1, pat_a5, 1'b1, 1'b0);
    step("load_a5b", 1'b0, 6'b000000, 1'b1, pat_a5, 1'b1, 1'b0);
    stall = 6'b001111;
    #2;
    Rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.valid",  DW'(out_valid_o), '0);
    chk("arst.data",   out_data_o, '0);
    chk("arst.sticky", DW'(out_sticky_o), '0);
    chk("arst.bcnt",   DW'(bubble_cnt_o), '0);
    chk("arst.fcnt",   DW'(flush_cnt_o), '0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("post_rst.valid", DW'(out_valid_o), '0);
    step("post_rst_hold", 1'b0, 6'b001111, 1'b1, pat_a5, 1'b1, 1'b0);
    step("post_rst_adv", 1'b0, 6'b000000, 1'b1, DW'(128'hC0DE), 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
